// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter that picks one of four requesters per frame and serialises it as
// start bit, 2-bit port, 4-bit count, payload (LSB first) and an idle-high gap.
module serial_frame_arbiter #(
    parameter int GAP_BITS = 1,
    parameter int DATA_W   = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [3:0]          req,
    input  logic [15:0]         len_flat,
    input  logic [4*DATA_W-1:0] data_flat,
    output logic                serout,
    output logic [3:0]          gnt,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        PORT  = 3'd2,
        CNT   = 3'd3,
        DATA  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic [3:0] LAST_GAP = 4'(GAP_BITS - 1);

    state_t              r_state;
    logic [1:0]          r_rrPtr;
    logic [1:0]          r_winner;
    logic [3:0]          r_len;
    logic [3:0]          r_bitCnt;
    logic [DATA_W-1:0]   r_shift;

    logic [1:0]          w_pick;
    logic                w_anyReq;
    logic                w_grant;
    logic [3:0]          w_lenSel;
    logic [DATA_W-1:0]   w_dataSel;

    // Scan from the farthest offset down so the nearest set request at/after the pointer wins.
    always_comb begin
        w_pick   = r_rrPtr;
        w_anyReq = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_rrPtr + 2'(k)]) begin
                w_pick   = r_rrPtr + 2'(k);
                w_anyReq = 1'b1;
            end
        end
    end

    always_comb begin
        w_lenSel  = len_flat[3:0];
        w_dataSel = data_flat[DATA_W-1:0];
        case (w_pick)
            2'd0: begin
                w_lenSel  = len_flat[3:0];
                w_dataSel = data_flat[0*DATA_W +: DATA_W];
            end
            2'd1: begin
                w_lenSel  = len_flat[7:4];
                w_dataSel = data_flat[1*DATA_W +: DATA_W];
            end
            2'd2: begin
                w_lenSel  = len_flat[11:8];
                w_dataSel = data_flat[2*DATA_W +: DATA_W];
            end
            default: begin
                w_lenSel  = len_flat[15:12];
                w_dataSel = data_flat[3*DATA_W +: DATA_W];
            end
        endcase
    end

    // Grant is asserted in the deciding cycle so requesters see it at the same edge the frame starts.
    assign w_grant = rst_n && (r_state == IDLE) && clk_en && w_anyReq;
    assign gnt     = w_grant ? (4'b0001 << w_pick) : 4'b0000;
    assign busy    = (r_state != IDLE);
    assign done    = clk_en && (r_state == GAP) && (r_bitCnt == LAST_GAP);

    always_comb begin
        serout = 1'b1;
        case (r_state)
            IDLE:    serout = 1'b1;
            START:   serout = 1'b0;
            PORT:    serout = r_bitCnt[0] ? r_winner[0] : r_winner[1];
            CNT:     serout = r_len[2'd3 - r_bitCnt[1:0]];
            DATA:    serout = r_shift[0];
            GAP:     serout = 1'b1;
            default: serout = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rrPtr  <= 2'd0;
            r_winner <= 2'd0;
            r_len    <= 4'd0;
            r_bitCnt <= 4'd0;
            r_shift  <= '0;
        end else if (clk_en) begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_winner <= w_pick;
                        r_len    <= w_lenSel;
                        r_shift  <= w_dataSel;
                        r_rrPtr  <= w_pick + 2'd1;
                        r_bitCnt <= 4'd0;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_bitCnt <= 4'd0;
                    r_state  <= PORT;
                end
                PORT: begin
                    if (r_bitCnt == 4'd1) begin
                        r_bitCnt <= 4'd0;
                        r_state  <= CNT;
                    end else begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                end
                CNT: begin
                    if (r_bitCnt == 4'd3) begin
                        r_bitCnt <= 4'd0;
                        r_state  <= (r_len != 4'd0) ? DATA : GAP;
                    end else begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                end
                DATA: begin
                    r_shift <= r_shift >> 1;
                    if (r_bitCnt == r_len - 4'd1) begin
                        r_bitCnt <= 4'd0;
                        r_state  <= GAP;
                    end else begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                end
                GAP: begin
                    if (r_bitCnt == LAST_GAP) begin
                        r_bitCnt <= 4'd0;
                        r_state  <= IDLE;
                    end else begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                end
                default: begin
                    r_bitCnt <= 4'd0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: a frame-level model builds each expected bit stream from the
// grant rules and compares it, tick by tick, against two instances (gap of 1 and gap of 3).
module tb_serial_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [15:0] lenFlat = 16'h0000;
    logic [59:0] dataFlat = 60'h0;
    logic        sel = 1'b0;

    logic [3:0]  reqA, reqB;
    logic        seroutA, busyA, doneA;
    logic [3:0]  gntA;
    logic        seroutB, busyB, doneB;
    logic [3:0]  gntB;

    int vectors = 0;
    int miscompares = 0;
    int phase = 0;
    int enPeriod = 1;
    int mRr [2] = '{0, 0};

    assign reqA = sel ? 4'b0000 : req;
    assign reqB = sel ? req : 4'b0000;

    serial_frame_arbiter #(.GAP_BITS(1), .DATA_W(15)) dutA (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .req(reqA),
        .len_flat(lenFlat), .data_flat(dataFlat),
        .serout(seroutA), .gnt(gntA), .busy(busyA), .done(doneA)
    );

    serial_frame_arbiter #(.GAP_BITS(3), .DATA_W(15)) dutB (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .req(reqB),
        .len_flat(lenFlat), .data_flat(dataFlat),
        .serout(seroutB), .gnt(gntB), .busy(busyB), .done(doneB)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic obsSerout(); return sel ? seroutB : seroutA; endfunction
    function automatic logic obsBusy();   return sel ? busyB : busyA;     endfunction
    function automatic logic obsDone();   return sel ? doneB : doneA;     endfunction
    function automatic logic [3:0] obsGnt(); return sel ? gntB : gntA;    endfunction

    // Reference arbitration: first requester at or after the pointer, wrapping around.
    function automatic int pickWinner(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        phase++;
        clk_en = ((phase % enPeriod) == 0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mRr[0] = 0;
        mRr[1] = 0;
    endtask

    // Requests a frame, checks the grant, then checks every serial bit period up to done.
    task automatic runFrame(input logic [3:0] reqV, input bit dropWinner, input bit scramble,
                            input int stopAfter, output int winner);
        int w;
        int waited;
        int cyc;
        int lenV;
        int gapBits;
        logic [14:0] dV;
        logic [3:0] gExp;
        logic expDone;
        bit q[$];
        winner = -1;
        gapBits = sel ? 3 : 1;
        step();
        req = reqV;
        w = pickWinner(req, mRr[sel]);
        gExp = 4'b0001 << w;
        waited = 0;
        forever begin
            @(negedge clk);
            vectors++;
            if (clk_en) begin
                if (obsGnt() !== gExp || obsBusy() !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL grant: gnt=%b busy=%b, expected gnt=%b busy=0", obsGnt(), obsBusy(), gExp);
                end
                break;
            end else if (obsGnt() !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL grant_gated: gnt=%b with clk_en=0, expected 0000", obsGnt());
            end
            waited++;
            if (waited > 50) begin
                miscompares++;
                $display("[TB] FAIL grant_timeout: no clk_en tick within 50 cycles");
                return;
            end
            step();
        end
        winner = w;
        lenV = int'(lenFlat[4*w +: 4]);
        dV = dataFlat[15*w +: 15];
        mRr[sel] = (w + 1) % 4;
        q.push_back(1'b0);
        q.push_back(bit'((w >> 1) & 1));
        q.push_back(bit'(w & 1));
        for (int i = 3; i >= 0; i--) q.push_back(bit'((lenV >> i) & 1));
        for (int i = 0; i < lenV; i++) q.push_back(dV[i]);
        for (int i = 0; i < gapBits; i++) q.push_back(1'b1);
        for (int b = 0; b < q.size(); b++) begin
            cyc = 0;
            forever begin
                step();
                if (b == 0 && dropWinner) req[w] = 1'b0;
                if (scramble) begin
                    lenFlat = 16'($urandom());
                    dataFlat = 60'({$urandom(), $urandom()});
                end
                @(negedge clk);
                cyc++;
                vectors++;
                expDone = clk_en && (b == q.size() - 1);
                if (obsSerout() !== q[b] || obsBusy() !== 1'b1 || obsGnt() !== 4'b0000 || obsDone() !== expDone) begin
                    miscompares++;
                    $display("[TB] FAIL frame_bit %0d: serout=%b busy=%b gnt=%b done=%b, expected serout=%b busy=1 gnt=0000 done=%b",
                             b, obsSerout(), obsBusy(), obsGnt(), obsDone(), q[b], expDone);
                end
                if (clk_en) break;
                if (cyc > enPeriod + 2) begin
                    miscompares++;
                    $display("[TB] FAIL bit_timeout: bit %0d held beyond %0d cycles", b, cyc);
                    return;
                end
            end
            if (enPeriod > 1) begin
                vectors++;
                if (cyc != enPeriod) begin
                    miscompares++;
                    $display("[TB] FAIL bit_hold %0d: held %0d clk, expected %0d", b, cyc, enPeriod);
                end
            end
            if (b + 1 == stopAfter) return;
        end
    endtask

    task automatic test_reset();
        req = 4'b1111;
        clk_en = 1'b1;
        #2;
        vectors++;
        if (seroutA !== 1'b1 || busyA !== 1'b0 || gntA !== 4'b0000 || doneA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_A: serout=%b busy=%b gnt=%b done=%b, expected 1 0 0000 0", seroutA, busyA, gntA, doneA);
        end
        vectors++;
        if (seroutB !== 1'b1 || busyB !== 1'b0 || gntB !== 4'b0000 || doneB !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_B: serout=%b busy=%b gnt=%b done=%b, expected 1 0 0000 0", seroutB, busyB, gntB, doneB);
        end
        applyReset();
    endtask

    task automatic test_idle();
        enPeriod = 1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            vectors++;
            if (seroutA !== 1'b1 || busyA !== 1'b0 || gntA !== 4'b0000 || doneA !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle: serout=%b busy=%b gnt=%b done=%b, expected 1 0 0000 0", seroutA, busyA, gntA, doneA);
            end
        end
    endtask

    task automatic test_single_frame();
        int w;
        lenFlat = 16'h0030;
        dataFlat = 60'h0;
        dataFlat[29:15] = 15'b000000000000101;
        runFrame(4'b0010, 1'b1, 1'b0, -1, w);
        step();
        @(negedge clk);
        vectors++;
        if (busyA !== 1'b0 || seroutA !== 1'b1 || doneA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_frame: busy=%b serout=%b done=%b, expected 0 1 0", busyA, seroutA, doneA);
        end
    endtask

    task automatic test_round_robin();
        int w;
        applyReset();
        lenFlat = 16'h1111;
        dataFlat = 60'({$urandom(), $urandom()});
        runFrame(4'b1111, 1'b1, 1'b0, -1, w);
        for (int i = 0; i < 3; i++) runFrame(req, 1'b1, 1'b0, -1, w);
        runFrame(req | 4'b0101, 1'b1, 1'b0, -1, w);
        runFrame(req, 1'b1, 1'b0, -1, w);
    endtask

    task automatic test_zero_len();
        int w;
        lenFlat = 16'h0000;
        runFrame(4'b1000, 1'b1, 1'b0, -1, w);
    endtask

    task automatic test_long_gap();
        int w;
        sel = 1'b1;
        lenFlat = 16'h000F;
        dataFlat = 60'h0;
        dataFlat[14:0] = 15'h7FFF;
        runFrame(4'b0001, 1'b1, 1'b0, -1, w);
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        int w;
        lenFlat = 16'h000F;
        dataFlat = 60'h0;
        runFrame(4'b0001, 1'b1, 1'b0, 10, w);
        #2;
        rst_n = 1'b0;
        req = 4'b0011;
        clk_en = 1'b1;
        #1;
        vectors++;
        if (seroutA !== 1'b1 || busyA !== 1'b0 || gntA !== 4'b0000 || doneA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: serout=%b busy=%b gnt=%b done=%b, expected 1 0 0000 0", seroutA, busyA, gntA, doneA);
        end
        @(posedge clk);
        #2;
        req = 4'b0000;
        #1;
        rst_n = 1'b1;
        mRr[0] = 0;
        mRr[1] = 0;
        runFrame(4'b0011, 1'b1, 1'b0, -1, w);
    endtask

    task automatic test_slow_enable();
        int w;
        enPeriod = 4;
        lenFlat = 16'h0020;
        dataFlat = 60'({$urandom(), $urandom()});
        runFrame(4'b0010, 1'b1, 1'b0, -1, w);
        enPeriod = 1;
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 25; n++) begin
            enPeriod = $urandom_range(1, 3);
            lenFlat = 16'($urandom());
            dataFlat = 60'({$urandom(), $urandom()});
            runFrame(4'($urandom_range(1, 15)), bit'($urandom_range(0, 1)), 1'b1, -1, w);
        end
        enPeriod = 1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_frame();
        test_round_robin();
        test_zero_len();
        test_long_gap();
        test_async_reset();
        test_slow_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
